rr_arb_mux: RTL and testbench

- Parametrised successor to the team's 4:1 combinational mux: NUM_CH channels of WIDTH-bit data, each with a valid/ready handshake, merged onto one registered output stream.
- Selection is made by a round-robin arbiter, with a runtime fixed-priority override, instead of an external select.
- Sits wherever several producers share one consumer, e.g. request merging ahead of a shared bus or FIFO.

---
 rtl/rr_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/rr_arb_mux.sv | 74 +++++++
 tb/tb_rr_arb_mux.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, constants and helpers for the round-robin arbitrated mux
package rr_arb_pkg;

  // Default configuration; modules with other NUM_CH values size their own index ports.
  localparam int NUM_CH_DEF = 4;
  localparam int CH_W_DEF   = $clog2(NUM_CH_DEF);

  typedef logic [CH_W_DEF-1:0] ch_idx_t;

  // Pointer value after reset: last channel, so the first search starts at channel 0.
  localparam ch_idx_t RR_RESET_PTR = ch_idx_t'(NUM_CH_DEF - 1);

  // Reset pointer for an arbitrary channel count.
  function automatic int rr_reset_ptr(input int num_ch);
    return num_ch - 1;
  endfunction

  // Channel visited at search step k when the last grant went to ptr.
  function automatic int rr_slot(input int ptr, input int k, input int num_ch);
    return (ptr + 1 + k) % num_ch;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority grant generator
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  input  logic              i_fixed_pri,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);

  // Walk channels in priority order and grant the first requester found.
  always_comb begin
    int w_slot;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_slot  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_slot = i_fixed_pri ? k : rr_slot(int'(i_ptr), k, NUM_CH);
      if (!o_any && i_req[w_slot]) begin
        o_grant[w_slot] = 1'b1;
        o_idx           = CH_W'(w_slot);
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - NUM_CH-way valid/ready merge onto one registered output stream
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    fixed_pri,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  localparam logic [CH_W-1:0] L_RESET_PTR = CH_W'(rr_reset_ptr(NUM_CH));

  logic [CH_W-1:0]   r_rr_ptr;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [CH_W-1:0]   r_out_ch;

  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic              w_load_en;
  logic              w_xfer;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arbiter (
    .i_req       (in_valid),
    .i_ptr       (r_rr_ptr),
    .i_fixed_pri (fixed_pri),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  // Output slot is free when empty or being drained this cycle; ready is held low in reset.
  always_comb begin
    w_load_en = !r_out_valid || out_ready;
    in_ready  = (rst_n && w_load_en) ? w_grant : '0;
    w_xfer    = rst_n && w_load_en && w_any;
  end

  // Output register and round-robin pointer; the pointer tracks the last grant in both modes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= L_RESET_PTR;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[int'(w_idx)*WIDTH +: WIDTH];
      r_out_ch    <= w_idx;
      r_rr_ptr    <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - vector table plus scoreboard bench for rr_arb_mux
module tb_rr_arb_mux;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    fixed_pri;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_ch;
  logic                    out_ready;

  rr_arb_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fixed_pri (fixed_pri),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       fp;
    logic       ordy;
    logic [7:0] base;
    logic [3:0] rdy;
    logic       ov;
    logic       zc;
  } vec_t;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    m_ptr  = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic rst, input logic [3:0] v, input logic fp, input logic ordy,
                     input logic [7:0] base, input logic [3:0] rdy, input logic ov, input logic zc);
    vec_t r;
    r.rst = rst; r.v = v; r.fp = fp; r.ordy = ordy;
    r.base = base; r.rdy = rdy; r.ov = ov; r.zc = zc;
    tbl.push_back(r);
  endtask

  function automatic int model_grant(input logic [3:0] v, input logic fp, input int ptr);
    int c;
    for (int k = 0; k < NUM_CH; k++) begin
      c = fp ? k : (ptr + 1 + k) % NUM_CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int          g;
    logic        m_load;
    logic [3:0]  m_rdy;
    beat_t       b;

    //   rst  valid  fp   ordy  base   rdy    ov   zc
    // reset held with all channels requesting
    add(1'b0, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h0, 1'b0, 1'b1);
    add(1'b0, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h0, 1'b0, 1'b1);
    // fairness: grants 0,1,2,3,0,1,2,3 then drain
    add(1'b1, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h1, 1'b0, 1'b0);
    add(1'b1, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h2, 1'b1, 1'b0);
    add(1'b1, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h4, 1'b1, 1'b0);
    add(1'b1, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h8, 1'b1, 1'b0);
    add(1'b1, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h1, 1'b1, 1'b0);
    add(1'b1, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h2, 1'b1, 1'b0);
    add(1'b1, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h4, 1'b1, 1'b0);
    add(1'b1, 4'hF, 1'b0, 1'b1, 8'hA0, 4'h8, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b0, 1'b1, 8'hA0, 4'h0, 1'b1, 1'b0);
    // backpressure: ch1 accepted, 3 stalled cycles, ch2 granted on release
    add(1'b1, 4'h6, 1'b0, 1'b0, 8'hB0, 4'h2, 1'b0, 1'b0);
    add(1'b1, 4'h6, 1'b0, 1'b0, 8'hB0, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h6, 1'b0, 1'b0, 8'hB0, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h6, 1'b0, 1'b0, 8'hB0, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h6, 1'b0, 1'b1, 8'hB0, 4'h4, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b0, 1'b1, 8'hB0, 4'h0, 1'b1, 1'b0);
    // fixed priority: four beats from ch1, then round-robin picks ch3
    add(1'b1, 4'hA, 1'b1, 1'b1, 8'hC0, 4'h2, 1'b0, 1'b0);
    add(1'b1, 4'hA, 1'b1, 1'b1, 8'hC0, 4'h2, 1'b1, 1'b0);
    add(1'b1, 4'hA, 1'b1, 1'b1, 8'hC0, 4'h2, 1'b1, 1'b0);
    add(1'b1, 4'hA, 1'b1, 1'b1, 8'hC0, 4'h2, 1'b1, 1'b0);
    add(1'b1, 4'hA, 1'b0, 1'b1, 8'hC0, 4'h8, 1'b1, 1'b0);
    // sparse and wrap: ptr=3, only ch2 valid, then idle
    add(1'b1, 4'h4, 1'b0, 1'b1, 8'hD0, 4'h4, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b0, 1'b1, 8'hD0, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b0, 1'b1, 8'hD0, 4'h0, 1'b0, 1'b0);
    // mid-operation reset while a beat is stalled
    add(1'b1, 4'h1, 1'b0, 1'b0, 8'hE0, 4'h1, 1'b0, 1'b0);
    add(1'b1, 4'h0, 1'b0, 1'b0, 8'hE0, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'h0, 1'b0, 1'b0, 8'hE0, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h3, 1'b0, 1'b1, 8'hF0, 4'h1, 1'b0, 1'b1);
    add(1'b1, 4'h3, 1'b0, 1'b1, 8'hF0, 4'h2, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b0, 1'b1, 8'hF0, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h0, 1'b0, 1'b1, 8'hF0, 4'h0, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = '0; in_data = '0; fixed_pri = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < tbl.size(); r++) begin
      rst_n     = tbl[r].rst;
      in_valid  = tbl[r].v;
      fixed_pri = tbl[r].fp;
      out_ready = tbl[r].ordy;
      for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = tbl[r].base + 8'(i);

      @(negedge clk);
      // model grant for this cycle
      m_load = (sb.size() == 0) || out_ready;
      g      = model_grant(in_valid, fixed_pri, m_ptr);
      m_rdy  = (rst_n && m_load && g >= 0) ? 4'(1 << g) : 4'h0;

      chk($sformatf("row%0d in_ready", r), 32'(in_ready), 32'(tbl[r].rdy));
      chk($sformatf("row%0d in_ready_model", r), 32'(in_ready), 32'(m_rdy));
      chk($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(tbl[r].ov));
      chk($sformatf("row%0d out_valid_sb", r), 32'(out_valid), 32'(sb.size() != 0));
      if (tbl[r].zc) begin
        chk($sformatf("row%0d out_data_zero", r), 32'(out_data), 32'h0);
        chk($sformatf("row%0d out_ch_zero", r), 32'(out_ch), 32'h0);
      end
      if (sb.size() != 0) begin
        chk($sformatf("row%0d out_ch", r), 32'(out_ch), 32'(sb[0].ch));
        chk($sformatf("row%0d out_data", r), 32'(out_data), 32'(sb[0].data));
      end

      // advance the scoreboard to the state after the coming edge
      if (!rst_n) begin
        sb.delete();
        m_ptr = 3;
      end else begin
        if (sb.size() != 0 && out_ready) void'(sb.pop_front());
        if (m_load && g >= 0) begin
          b.ch   = g;
          b.data = tbl[r].base + 8'(g);
          sb.push_back(b);
          m_ptr = g;
        end
      end

      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
